fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage pipeline: owns the program counter, drives the chip-enable and address of the combinational instruction ROM, and registers the returned word with its PC into the IF/ID pipeline register consumed by decode. Handles sequential advance, branch redirect, pipeline stall (with a pending-branch latch) and exception flush.

---
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: ID-stage control into fetch, the ROM port, and the IF/ID register outputs.
// master: the fetch unit (drives rom_ce/rom_addr and the IF/ID fields, reads controls and rom_inst).
// slave: the surrounding pipeline/ROM (drives controls and rom_inst, reads everything else).
interface fetch_if;
  logic        stall_pc;
  logic        stall_id;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [31:0] fetch_count;

  modport master (
    input  stall_pc, stall_id, flush, new_pc, branch_flag, branch_target, rom_inst,
    output rom_ce, rom_addr, id_pc, id_inst, id_valid, fetch_count
  );

  modport slave (
    output stall_pc, stall_id, flush, new_pc, branch_flag, branch_target, rom_inst,
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the combinational ROM and registers word+PC into IF/ID.
// Latency: ROM word appears in IF/ID one edge after its address is on rom_addr; 1 instr/cycle.
// Backpressure: stall_pc holds the PC (latching any branch as pending), stall_id holds IF/ID.
// Ports: clk, rst (async active-high), bus (fetch_if.master: controls, ROM port, IF/ID outputs).
module fetch_unit #(
  parameter logic [31:0] RESET_PC             = 32'h0000_0000,
  parameter bit          FLUSH_CLEARS_PENDING = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_vld_q, id_vld_d;
  logic [31:0] cnt_q, cnt_d;
  logic        rom_ce;

  // Word alignment by masking; misaligned targets are silently truncated here.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

  // Chip enable is decoded from the registered state so it drops the instant rst rises.
  assign rom_ce = (state_q == S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'h0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= 32'h0;
      id_vld_q   <= 1'b0;
      cnt_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_vld_q   <= id_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  // State and PC / pending-branch next values.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    case (state_q)
      S_IDLE: begin
        // PC sits at RESET_PC so the first FETCH cycle presents it to the ROM.
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.flush) begin
          pc_d = word_align(bus.new_pc);
          if (FLUSH_CLEARS_PENDING) begin
            pend_vld_d = 1'b0;
            pend_tgt_d = 32'h0;
          end
        end else if (bus.stall_pc) begin
          // A branch resolved while IF is frozen must not be lost; newest one wins.
          if (bus.branch_flag) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = word_align(bus.branch_target);
          end
        end else if (bus.branch_flag) begin
          pc_d       = word_align(bus.branch_target);
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          pc_d       = pend_tgt_q;
          pend_vld_d = 1'b0;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IF/ID register and delivered-instruction counter.
  always_comb begin
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    id_vld_d  = id_vld_q;
    cnt_d     = cnt_q;
    if (bus.flush) begin
      id_pc_d   = 32'h0;
      id_inst_d = 32'h0;
      id_vld_d  = 1'b0;
    end else if (bus.stall_id) begin
      // hold
    end else if (bus.stall_pc || !rom_ce) begin
      // PC frozen (or ROM not yet enabled): feed decode a bubble rather than a duplicate.
      id_pc_d   = 32'h0;
      id_inst_d = 32'h0;
      id_vld_d  = 1'b0;
    end else begin
      // The word already in flight when a branch arrives is the delay slot and is kept.
      id_pc_d   = pc_q;
      id_inst_d = bus.rom_inst;
      id_vld_d  = 1'b1;
      cnt_d     = cnt_q + 32'd1;
    end
  end

  assign bus.rom_ce      = rom_ce;
  assign bus.rom_addr    = pc_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_inst     = id_inst_q;
  assign bus.id_valid    = id_vld_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(RPC), .FLUSH_CLEARS_PENDING(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h0000_00A0;
  endfunction

  assign bus.rom_inst = rom_fn(bus.rom_addr);

  // Behavioural model: what the pipeline should look like after each edge.
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_ptgt;
  logic [31:0] m_idpc;
  logic [31:0] m_idinst;
  bit          m_idv;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_run = 0; m_pc = RPC; m_pend = 0; m_ptgt = 0;
    m_idpc = 0; m_idinst = 0; m_idv = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [31:0] npc;
    bit          npend;
    logic [31:0] nptgt;
    npc = m_pc; npend = m_pend; nptgt = m_ptgt;
    if (m_run) begin
      if (bus.flush) begin
        npc = {bus.new_pc[31:2], 2'b00}; npend = 0;
      end else if (bus.stall_pc) begin
        if (bus.branch_flag) begin npend = 1; nptgt = {bus.branch_target[31:2], 2'b00}; end
      end else if (bus.branch_flag) begin
        npc = {bus.branch_target[31:2], 2'b00}; npend = 0;
      end else if (m_pend) begin
        npc = m_ptgt; npend = 0;
      end else begin
        npc = m_pc + 4;
      end
    end
    if (bus.flush || (!bus.stall_id && (bus.stall_pc || !m_run))) begin
      m_idpc = 0; m_idinst = 0; m_idv = 0;
    end else if (!bus.stall_id) begin
      m_idpc = m_pc; m_idinst = rom_fn(m_pc); m_idv = 1; m_cnt = m_cnt + 1;
    end
    m_pc = npc; m_pend = npend; m_ptgt = nptgt; m_run = 1;
  endtask

  // Advance one clock; inputs must already be set. Leaves time at edge+1.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall_pc = 0; bus.stall_id = 0; bus.flush = 0; bus.new_pc = 0;
    bus.branch_flag = 0; bus.branch_target = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #2;
    model_reset();
    n_checks++; if (bus.rom_ce !== 1'b0) $display("FAIL reset_rom_ce got %b want 0", bus.rom_ce); else n_pass++;
    n_checks++; if (bus.rom_addr !== RPC) $display("FAIL reset_pc got %h want %h", bus.rom_addr, RPC); else n_pass++;
    n_checks++; if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0)
      $display("FAIL reset_ifid got v=%b pc=%h inst=%h want 0/0/0", bus.id_valid, bus.id_pc, bus.id_inst); else n_pass++;
    n_checks++; if (bus.fetch_count !== 32'h0) $display("FAIL reset_count got %0d want 0", bus.fetch_count); else n_pass++;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h0, 32'h4, 32'h8};
    bit          exp_v  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++; if (bus.rom_ce !== 1'b1) $display("FAIL seq_rom_ce[%0d] got %b want 1", i, bus.rom_ce); else n_pass++;
      n_checks++; if (bus.id_valid !== exp_v[i] || bus.id_pc !== exp_pc[i])
        $display("FAIL seq_ifid[%0d] got v=%b pc=%h want v=%b pc=%h", i, bus.id_valid, bus.id_pc, exp_v[i], exp_pc[i]); else n_pass++;
      if (exp_v[i]) begin
        n_checks++; if (bus.id_inst !== rom_fn(exp_pc[i]))
          $display("FAIL seq_inst[%0d] got %h want %h", i, bus.id_inst, rom_fn(exp_pc[i])); else n_pass++;
      end
    end
    n_checks++; if (bus.fetch_count !== 32'd3) $display("FAIL seq_count got %0d want 3", bus.fetch_count); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    cycle(); cycle(); cycle();
    n_checks++; if (bus.rom_addr !== 32'h8) $display("FAIL br_start_pc got %h want 00000008", bus.rom_addr); else n_pass++;
    bus.branch_flag = 1; bus.branch_target = 32'h40;
    cycle();
    bus.branch_flag = 0;
    n_checks++; if (bus.rom_addr !== 32'h40 || bus.id_pc !== 32'h8 || bus.id_valid !== 1'b1)
      $display("FAIL br_delay_slot got pc=%h id_pc=%h v=%b want 40/8/1", bus.rom_addr, bus.id_pc, bus.id_valid); else n_pass++;
    cycle();
    n_checks++; if (bus.rom_addr !== 32'h44 || bus.id_pc !== 32'h40 || bus.id_inst !== rom_fn(32'h40))
      $display("FAIL br_target got pc=%h id_pc=%h inst=%h want 44/40/%h", bus.rom_addr, bus.id_pc, bus.id_inst, rom_fn(32'h40)); else n_pass++;
  endtask

  task automatic test_stall_bubble();
    logic [31:0] held;
    held = m_pc;
    bus.stall_pc = 1; bus.branch_flag = 1; bus.branch_target = 32'h100;
    cycle();
    bus.branch_flag = 0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) cycle();
      n_checks++; if (bus.rom_addr !== held || bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0)
        $display("FAIL stall_bubble[%0d] got pc=%h v=%b inst=%h want %h/0/0", i, bus.rom_addr, bus.id_valid, bus.id_inst, held); else n_pass++;
    end
    bus.stall_pc = 0;
    cycle();
    n_checks++; if (bus.rom_addr !== 32'h100) $display("FAIL stall_pending_apply got %h want 00000100", bus.rom_addr); else n_pass++;
    cycle();
    n_checks++; if (bus.id_pc !== 32'h100 || bus.id_valid !== 1'b1) $display("FAIL stall_after got id_pc=%h v=%b want 100/1", bus.id_pc, bus.id_valid); else n_pass++;
  endtask

  task automatic test_stall_freeze();
    logic [31:0] pc0, idpc0, inst0, cnt0;
    pc0 = m_pc; idpc0 = m_idpc; inst0 = m_idinst; cnt0 = m_cnt;
    bus.stall_pc = 1; bus.stall_id = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (bus.rom_addr !== pc0 || bus.id_pc !== idpc0 || bus.id_inst !== inst0 || bus.id_valid !== 1'b1 || bus.fetch_count !== cnt0)
        $display("FAIL freeze[%0d] got pc=%h id=%h/%h v=%b cnt=%0d want %h %h/%h 1 %0d", i, bus.rom_addr, bus.id_pc, bus.id_inst, bus.id_valid, bus.fetch_count, pc0, idpc0, inst0, cnt0); else n_pass++;
    end
    bus.stall_pc = 0; bus.stall_id = 0;
    cycle();
  endtask

  task automatic test_flush();
    bus.stall_pc = 1; bus.branch_flag = 1; bus.branch_target = 32'h300;
    cycle();
    bus.branch_flag = 0; bus.flush = 1; bus.new_pc = 32'h0000_0182;
    cycle();
    bus.flush = 0; bus.stall_pc = 0;
    n_checks++; if (bus.rom_addr !== 32'h180 || bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0)
      $display("FAIL flush got pc=%h v=%b id=%h/%h want 180/0/0/0", bus.rom_addr, bus.id_valid, bus.id_pc, bus.id_inst); else n_pass++;
    cycle();
    n_checks++; if (bus.rom_addr !== 32'h184 || bus.id_pc !== 32'h180) $display("FAIL flush_next got pc=%h id_pc=%h want 184/180", bus.rom_addr, bus.id_pc); else n_pass++;
    cycle();
    n_checks++; if (bus.rom_addr !== 32'h188) $display("FAIL flush_no_pending got pc=%h want 188", bus.rom_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    bus.flush = 1; bus.new_pc = 32'hFFFF_FFFF;
    cycle();
    bus.flush = 0;
    n_checks++; if (bus.rom_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_start got %h want fffffffc", bus.rom_addr); else n_pass++;
    cycle();
    n_checks++; if (bus.rom_addr !== 32'h0 || bus.id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap got pc=%h id_pc=%h want 0/fffffffc", bus.rom_addr, bus.id_pc); else n_pass++;
  endtask

  task automatic test_async_reset();
    bus.stall_pc = 1; bus.branch_flag = 1; bus.branch_target = 32'h500;
    cycle();
    #3;
    rst = 1;
    #1;
    model_reset();
    n_checks++; if (bus.rom_ce !== 1'b0 || bus.id_valid !== 1'b0 || bus.rom_addr !== RPC || bus.fetch_count !== 32'h0)
      $display("FAIL async_rst got ce=%b v=%b pc=%h cnt=%0d want 0/0/%h/0", bus.rom_ce, bus.id_valid, bus.rom_addr, bus.fetch_count, RPC); else n_pass++;
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    cycle(); cycle();
    n_checks++; if (bus.rom_addr !== 32'h4) $display("FAIL async_rst_no_pending got pc=%h want 4", bus.rom_addr); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.flush         = ($urandom_range(0, 19) == 0);
      bus.stall_pc      = ($urandom_range(0, 4) == 0);
      bus.stall_id      = ($urandom_range(0, 5) == 0);
      bus.branch_flag   = ($urandom_range(0, 5) == 0);
      bus.branch_target = $urandom();
      bus.new_pc        = $urandom();
      cycle();
      n_checks++;
      if (bus.rom_ce !== 1'b1 || bus.rom_addr !== m_pc || bus.id_pc !== m_idpc || bus.id_inst !== m_idinst ||
          bus.id_valid !== m_idv || bus.fetch_count !== m_cnt)
        $display("FAIL random[%0d] got pc=%h id=%h/%h v=%b cnt=%0d want %h %h/%h %b %0d", i, bus.rom_addr, bus.id_pc, bus.id_inst, bus.id_valid, bus.fetch_count, m_pc, m_idpc, m_idinst, m_idv, m_cnt);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_bubble();
    test_stall_freeze();
    test_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
